shift_reg_seq: RTL
==================

Name: shift_reg_seq

Overview:
- Parametrised, sequenced successor to the team's 8-bit mode-select shift register.
- Same eight operation modes, generalised to WIDTH bits.
- Multi-position shifts/rotates execute one position per clock under a start/busy/done handshake.
- Adds a serial fill input and a registered serial output. Used wherever a datapath needs shift-by-N without a barrel shifter.

Parameters:
WIDTH, 8, register width in bits (>=2)
AMT_W, $clog2(WIDTH)+1, width of shift-amount input; amounts up to 2**AMT_W-1 are legal

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  request; accepted only when busy=0
mode  input  3  operation code, sampled on accept
amount  input  AMT_W  number of single-position steps, sampled on accept
d  input  WIDTH  parallel load data, sampled on accept
ser_in  input  1  serial fill bit for mode 101, sampled on every step edge
q  output  WIDTH  register contents
busy  output  1  multi-step operation in progress
done  output  1  one-cycle completion pulse
ser_out  output  1  bit most recently shifted or rotated out

Behaviour:
- Reset: clk is the single clock; rst is asynchronous and active-high. While rst=1: q=0, busy=0, done=0, ser_out=0, step counter=0, FSM=IDLE.
- Reset mid-operation aborts the operation immediately. No done pulse follows.
- Modes, one step each:
  - 000 clear: q=0
  - 001 load: q=d
  - 010 logical right, 0 fill at MSB
  - 011 logical left, 0 fill at LSB
  - 100 arithmetic right, MSB replicated
  - 101 right shift, ser_in fills MSB
  - 110 rotate right
  - 111 rotate left
- ser_out on every shift/rotate step edge: right modes capture old q[0]; left modes capture old q[WIDTH-1].
- ser_out is unchanged by clear, load and amount-0 operations.
- FSM states: IDLE, SHIFT.
- Accept: edge with FSM=IDLE and start=1. mode and amount are latched; later changes on those inputs are ignored until done.
- Clear/load: applied on the accept edge. Stay IDLE. done=1 for the following cycle.
- Shift/rotate with amount=0: q unchanged. done=1 for the following cycle.
- Shift/rotate with amount=N>=1:
  - Step 1 is applied on the accept edge and the counter is set to N-1.
  - If N-1>0: go to SHIFT, busy=1.
  - In SHIFT, each edge applies one step and decrements the counter. The edge applying step N returns to IDLE, clears busy and sets done for one cycle.
  - Net result: q reflects all N steps N-1 edges after accept. done is high in the cycle after the final step edge.
- Amounts >= WIDTH are executed literally:
  - logical shifts end at 0
  - arithmetic right ends at all-sign
  - rotates end at the rotation by N mod WIDTH
- start while busy=1 is ignored, not queued.
- start in the cycle where done=1 is accepted normally, giving back-to-back operations.
- done and busy are never high simultaneously. done is registered, not combinational.

Decomposition:
- Shared package/header: mode code constants MODE_CLR, MODE_LD, MODE_SRL, MODE_SLL, MODE_SRA, MODE_SRS, MODE_ROR, MODE_ROL, and FSM state encodings.
- Sub-module shift_step: purely combinational, WIDTH-parametrised single-step function.
  - Inputs: q, mode, ser_in, d.
  - Outputs: next q and the shifted-out bit.
  - Instantiated once.
- Counter and FSM live in the top.

Test Plan:
- WIDTH=8. Assert rst mid-stream -> q=00, busy=0, done=0, ser_out=0 immediately, without waiting for a clock edge. Release; mode=001, d=A5, start 1 cycle -> q=A5 after that edge, done=1 for exactly 1 cycle, busy stays 0.
- q=96, mode=100, amount=3 -> busy high 2 cycles, q=CB,E5,F2 on successive edges, ser_out=1 after final step, done pulse follows final edge.
- q=81, mode=111, amount=10 -> final q=06, busy high 9 cycles; start pulses with mode=000 during busy are ignored (q never 00).
- q=00, mode=101, amount=3, ser_in=1,0,1 on the step edges -> q=80,40,A0; then mode=010, amount=0 -> q stays A0, done next cycle.
- q=FF, mode=011, amount=5; assert rst after 2 steps -> q=00 asynchronously, no done pulse. After release a new load is accepted on the first edge.
- Back-to-back: load 3C, then shift right amount 1 with start held through done -> q=3C then 1E on consecutive operations, two distinct done pulses.

Source files
------------

// File: rtl/shift_reg_seq_pkg.sv
// shift_reg_seq_pkg: mode codes, FSM states and mode classification shared by the shifter
package shift_reg_seq_pkg;

    localparam logic [2:0] MODE_CLR = 3'b000;
    localparam logic [2:0] MODE_LD  = 3'b001;
    localparam logic [2:0] MODE_SRL = 3'b010;
    localparam logic [2:0] MODE_SLL = 3'b011;
    localparam logic [2:0] MODE_SRA = 3'b100;
    localparam logic [2:0] MODE_SRS = 3'b101;
    localparam logic [2:0] MODE_ROR = 3'b110;
    localparam logic [2:0] MODE_ROL = 3'b111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Every code other than clear and load is a multi-step shift or rotate
    function automatic logic is_step_mode(input logic [2:0] m);
        return m[2] | m[1];
    endfunction

endpackage

// File: rtl/shift_reg_seq_step.sv
// shift_step: single-position combinational shift/rotate/load/clear with shifted-out bit
module shift_step
    import shift_reg_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic [2:0]       mode_i,
    input  logic             ser_in_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic             out_o
);

    // One step of the selected operation; right moves expose bit 0, left moves expose the MSB
    always_comb begin
        q_o   = q_i;
        out_o = q_i[0];
        case (mode_i)
            MODE_CLR: q_o = '0;
            MODE_LD:  q_o = d_i;
            MODE_SRL: q_o = {1'b0, q_i[WIDTH-1:1]};
            MODE_SLL: begin
                q_o   = {q_i[WIDTH-2:0], 1'b0};
                out_o = q_i[WIDTH-1];
            end
            MODE_SRA: q_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
            MODE_SRS: q_o = {ser_in_i, q_i[WIDTH-1:1]};
            MODE_ROR: q_o = {q_i[0], q_i[WIDTH-1:1]};
            MODE_ROL: begin
                q_o   = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
                out_o = q_i[WIDTH-1];
            end
            default: q_o = q_i;
        endcase
    end

endmodule

// File: rtl/shift_reg_seq.sv
// shift_reg_seq: sequenced WIDTH-bit shift register, one position per clock under start/busy/done
module shift_reg_seq
    import shift_reg_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amount,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             ser_out
);

    state_t             state_q, state_d;
    logic [AMT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         mode_q, mode_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               ser_q, ser_d;
    logic               done_q, done_d;
    logic [2:0]         step_mode;
    logic [WIDTH-1:0]   step_q;
    logic               step_out;

    // The accept edge uses the live mode; later steps use the latched one
    assign step_mode = (state_q == ST_IDLE) ? mode : mode_q;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .q_i      (q_q),
        .mode_i   (step_mode),
        .ser_in_i (ser_in),
        .d_i      (d),
        .q_o      (step_q),
        .out_o    (step_out)
    );

    // Next-state: accept in IDLE applies step 1 at once, SHIFT counts down the remaining steps
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        q_d     = q_q;
        ser_d   = ser_q;
        done_d  = 1'b0;
        if (state_q == ST_IDLE) begin
            if (start) begin
                mode_d = mode;
                if (!is_step_mode(mode)) begin
                    q_d    = step_q;
                    done_d = 1'b1;
                end else if (amount == '0) begin
                    done_d = 1'b1;
                end else begin
                    q_d   = step_q;
                    ser_d = step_out;
                    cnt_d = amount - AMT_W'(1);
                    if (amount > AMT_W'(1)) state_d = ST_SHIFT;
                    else done_d = 1'b1;
                end
            end
        end else begin
            q_d   = step_q;
            ser_d = step_out;
            cnt_d = cnt_q - AMT_W'(1);
            if (cnt_q == AMT_W'(1)) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end
    end

    // State register; reset aborts any operation without a done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_CLR;
            q_q     <= '0;
            ser_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            q_q     <= q_d;
            ser_q   <= ser_d;
            done_q  <= done_d;
        end
    end

    assign q       = q_q;
    assign busy    = (state_q == ST_SHIFT);
    assign done    = done_q;
    assign ser_out = ser_q;

endmodule
